// File: rtl/alink_dispatch_pkg.sv
// alink_dispatch_pkg
//   Shared definitions for the ALINK task dispatcher: dispatcher state
//   encoding, default task geometry / timing values and the miner select
//   width. Imported by alink_rr_arb and alink_dispatch.
package alink_dispatch_pkg;

  // Default geometry and timing of one dispatched task.
  localparam int DEF_NUM_MINER  = 32;
  localparam int DEF_TASK_WORDS = 23;
  localparam int DEF_GAP        = 2;
  localparam int DEF_TIMEOUT    = 1024;

  // Miner select width; covers up to 32 miner channels.
  localparam int SEL_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

endpackage

// File: rtl/alink_rr_arb.sv
// alink_rr_arb
//   Combinational round-robin search over the eligible miners. The search
//   starts at ptr+1 and wraps at NUM_MINER; the first eligible miner wins.
// Ports
//   elig      in  NUM_MINER  1 = miner may receive a task
//   ptr       in  SEL_W      index of the miner granted last
//   grant_idx out SEL_W      winning miner index (0 when nothing is eligible)
//   grant_vld out 1          at least one miner is eligible
module alink_rr_arb
  import alink_dispatch_pkg::*;
#(
  parameter int NUM_MINER = DEF_NUM_MINER
) (
  input  logic [NUM_MINER-1:0] elig,
  input  logic [SEL_W-1:0]     ptr,
  output logic [SEL_W-1:0]     grant_idx,
  output logic                 grant_vld
);

  localparam logic [NUM_MINER-1:0] ONE_HOT0 = NUM_MINER'(1);

  // Walk the candidates in priority order; the first hit is latched and
  // later hits leave the grant untouched.
  always_comb begin : search
    int   cand;
    logic hit;
    logic take;
    grant_idx = '0;
    grant_vld = 1'b0;
    cand      = 0;
    hit       = 1'b0;
    take      = 1'b0;
    for (int i = 1; i <= NUM_MINER; i++) begin
      cand      = int'(ptr) + i;
      cand      = (cand >= NUM_MINER) ? (cand - NUM_MINER) : cand;
      hit       = |(elig & (ONE_HOT0 << cand));
      take      = hit & ~grant_vld;
      grant_idx = take ? SEL_W'(cand) : grant_idx;
      grant_vld = grant_vld | hit;
    end
  end

endmodule

// File: rtl/alink_dispatch.sv
// alink_dispatch
//   Task scheduler between the ALINK TX FIFO and the miner PHY channels.
//   When scanning is enabled and the FIFO holds a whole task, it picks the
//   next enabled, idle miner round-robin and streams TASK_WORDS words to it.
// Ports
//   clk, rst             clock; synchronous active-high reset
//   reg_scan/mask/flush  dispatcher control from alink_slave
//   busy                 per-miner busy flags (busy miners are skipped)
//   txcnt, txfifo_dout   TX FIFO fill level and head word (FWFT)
//   txfifo_pop           consume head word (same cycle as a transfer)
//   tx_vld/data/last/sel word stream toward the selected PHY
//   tx_rdy               selected PHY accepts the word
//   tx_abort/tx_timeout  1-cycle pulses on a cut-short task / stall timeout
//   dispatch_cnt         completed tasks, wrapping
module alink_dispatch
  import alink_dispatch_pkg::*;
#(
  parameter int NUM_MINER  = DEF_NUM_MINER,
  parameter int TASK_WORDS = DEF_TASK_WORDS,
  parameter int GAP        = DEF_GAP,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 reg_scan,
  input  logic [NUM_MINER-1:0] reg_mask,
  input  logic                 reg_flush,
  input  logic [NUM_MINER-1:0] busy,
  input  logic [10:0]          txcnt,
  input  logic [31:0]          txfifo_dout,
  output logic                 txfifo_pop,
  output logic                 tx_vld,
  output logic [31:0]          tx_data,
  output logic                 tx_last,
  output logic [SEL_W-1:0]     tx_sel,
  input  logic                 tx_rdy,
  output logic                 tx_abort,
  output logic                 tx_timeout,
  output logic [31:0]          dispatch_cnt
);

  localparam int WCNT_W  = $clog2(TASK_WORDS);
  localparam int STALL_W = $clog2(TIMEOUT + 1);
  localparam int GAP_W   = $clog2(GAP + 1);

  localparam logic [WCNT_W-1:0]  WCNT_LAST  = WCNT_W'(TASK_WORDS - 1);
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT - 1);
  // GAP is expected to be at least 1 so the busy flags can settle.
  localparam logic [GAP_W-1:0]   GAP_LAST   = GAP_W'(GAP - 1);
  localparam logic [10:0]        TXCNT_MIN  = 11'(TASK_WORDS);
  localparam logic [SEL_W-1:0]   PTR_RST    = SEL_W'(NUM_MINER - 1);

  state_e               state_q, state_d;
  logic [WCNT_W-1:0]    wcnt_q, wcnt_d;
  logic [GAP_W-1:0]     gap_q, gap_d;
  logic [STALL_W-1:0]   stall_q, stall_d;
  logic [SEL_W-1:0]     ptr_q, ptr_d;
  logic [SEL_W-1:0]     sel_q, sel_d;
  logic                 vld_q, vld_d;
  logic                 last_q, last_d;
  logic                 abort_q, abort_d;
  logic                 timeout_q, timeout_d;
  logic [31:0]          dcnt_q, dcnt_d;

  logic [NUM_MINER-1:0] elig_s;
  logic [SEL_W-1:0]     grant_idx_s;
  logic                 grant_vld_s;
  logic                 xfer_s;
  logic                 start_s;

  assign elig_s  = reg_mask & ~busy;
  assign xfer_s  = vld_q & tx_rdy;
  assign start_s = reg_scan & (txcnt >= TXCNT_MIN) & grant_vld_s & ~reg_flush;

  alink_rr_arb #(
    .NUM_MINER (NUM_MINER)
  ) u_arb (
    .elig      (elig_s),
    .ptr       (ptr_q),
    .grant_idx (grant_idx_s),
    .grant_vld (grant_vld_s)
  );

  assign txfifo_pop   = xfer_s;
  assign tx_data      = txfifo_dout;
  assign tx_vld       = vld_q;
  assign tx_last      = last_q;
  assign tx_sel       = sel_q;
  assign tx_abort     = abort_q;
  assign tx_timeout   = timeout_q;
  assign dispatch_cnt = dcnt_q;

  // Next-state logic for the dispatcher FSM and all its counters.
  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    gap_d     = gap_q;
    stall_d   = stall_q;
    ptr_d     = ptr_q;
    sel_d     = sel_q;
    vld_d     = vld_q;
    abort_d   = 1'b0;
    timeout_d = 1'b0;
    dcnt_d    = dcnt_q;
    case (state_q)
      ST_IDLE: begin
        vld_d   = 1'b0;
        stall_d = '0;
        if (start_s) begin
          state_d = ST_SEND;
          sel_d   = grant_idx_s;
          ptr_d   = grant_idx_s;
          wcnt_d  = '0;
          vld_d   = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (reg_flush) begin
          // Only a task that has already handed out words counts as aborted.
          state_d = ST_IDLE;
          vld_d   = 1'b0;
          abort_d = (wcnt_q != '0);
        end else if (xfer_s) begin
          stall_d = '0;
          if (wcnt_q == WCNT_LAST) begin
            state_d = ST_GAP;
            vld_d   = 1'b0;
            gap_d   = '0;
            dcnt_d  = dcnt_q + 32'd1;
          end else begin
            wcnt_d = wcnt_q + WCNT_W'(1);
          end
        end else if (stall_q == STALL_LAST) begin
          // This is the TIMEOUT-th consecutive stalled cycle.
          state_d   = ST_IDLE;
          vld_d     = 1'b0;
          abort_d   = 1'b1;
          timeout_d = 1'b1;
        end else begin
          stall_d = stall_q + STALL_W'(1);
        end
      end
      ST_GAP: begin
        vld_d = 1'b0;
        if (reg_flush || (gap_q == GAP_LAST)) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        vld_d   = 1'b0;
      end
    endcase
    // Registered last-word flag, aligned with the word it marks.
    last_d = vld_d & (wcnt_d == WCNT_LAST);
  end

  // State, counter and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      wcnt_q    <= '0;
      gap_q     <= '0;
      stall_q   <= '0;
      ptr_q     <= PTR_RST;
      sel_q     <= '0;
      vld_q     <= 1'b0;
      last_q    <= 1'b0;
      abort_q   <= 1'b0;
      timeout_q <= 1'b0;
      dcnt_q    <= 32'd0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      gap_q     <= gap_d;
      stall_q   <= stall_d;
      ptr_q     <= ptr_d;
      sel_q     <= sel_d;
      vld_q     <= vld_d;
      last_q    <= last_d;
      abort_q   <= abort_d;
      timeout_q <= timeout_d;
      dcnt_q    <= dcnt_d;
    end
  end

endmodule
